// File: rtl/alu_operand_stage.sv
// Two-entry (main + skid) operand buffer in front of the ALU with a registered in_ready.
// Optional operand forwarding from the EX/MEM and MEM/WB buses: define ALU_OPERAND_FORWARD_EN.
module alu_operand_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALU_operation,
    output logic [4:0]  out_rd,
    input  logic        mem_we,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready_q, in_ready_d;
    logic   in_fire, out_fire;

    assign in_entry = '{valid: 1'b1, a: in_A, b: in_B, op: in_op,
                        rs: in_rs, rt: in_rt, rd: in_rd};

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = main_q.valid && out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (out_fire || !main_q.valid) begin
            // Main is free this edge: skid has priority so ordering is preserved.
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (in_fire) begin
                main_d = in_entry;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = in_entry;
        end
        in_ready_d = !skid_d.valid;
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is tested first so it outranks flush and every transfer.
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_q.valid;
    assign ALU_operation = main_q.op;
    assign out_rd        = main_q.rd;

`ifdef ALU_OPERAND_FORWARD_EN
    // Newest result wins: EX/MEM is checked before MEM/WB; register 0 is never forwarded.
    function automatic logic [31:0] forward(input logic [4:0] r, input logic [31:0] held);
        if (r != 5'd0 && mem_we && mem_rd == r)
            return mem_data;
        else if (r != 5'd0 && wb_we && wb_rd == r)
            return wb_data;
        else
            return held;
    endfunction

    assign A = forward(main_q.rs, main_q.a);
    assign B = forward(main_q.rt, main_q.b);
`else
    logic unused_bus;
    assign unused_bus = ^{mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
    assign A = main_q.a;
    assign B = main_q.b;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: accepted inputs are queued, a monitor checks outputs.
// Builds with or without ALU_OPERAND_FORWARD_EN; expectations follow the macro.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_A, in_B, A, B, mem_data, wb_data;
    logic [2:0]  in_op, ALU_operation;
    logic [4:0]  in_rs, in_rt, in_rd, out_rd, mem_rd, wb_rd;
    logic        mem_we, wb_we;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALU_operation(ALU_operation), .out_rd(out_rd),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Operand value the ALU should see for a register/held-value pair, given the current buses.
    function automatic logic [31:0] expect_operand(input logic [4:0] r, input logic [31:0] held);
`ifdef ALU_OPERAND_FORWARD_EN
        if (r != 0 && mem_we && mem_rd == r) return mem_data;
        if (r != 0 && wb_we && wb_rd == r) return wb_data;
`endif
        return held;
    endfunction

    // Acceptor: an input presented at an edge with in_ready=1 and no flush/reset joins the queue.
    initial begin
        item_t it;
        bit    fire;
        forever begin
            @(negedge clk);
            fire = (rst_n === 1'b1) && !flush && in_valid && in_ready;
            it   = '{a: in_A, b: in_B, op: in_op, rs: in_rs, rt: in_rt, rd: in_rd};
            @(posedge clk);
            if (fire) sb.push_back(it);
        end
    end

    // Monitor: queue size is the number of held entries; pop on each output transfer.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!rst_n || flush) begin
                    sb.delete();
                end else begin
                    check("in_ready_occupancy", 32'(in_ready), 32'(sb.size() < 2));
                    check("out_valid_occupancy", 32'(out_valid), 32'(sb.size() != 0));
                    if (out_valid && out_ready && sb.size() != 0) begin
                        e = sb.pop_front();
                        check("out_A", A, expect_operand(e.rs, e.a));
                        check("out_B", B, expect_operand(e.rt, e.b));
                        check("out_op", 32'(ALU_operation), 32'(e.op));
                        check("out_rd", 32'(out_rd), 32'(e.rd));
                    end
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        in_A = a; in_B = b; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_valid = 1'b1;
    endtask

    // Present one input and hold it until accepted (bounded); called at posedge+#1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bit acc = 1'b0;
        drive(a, b, op, rs, rt, rd);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !flush && rst_n;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_accept", 32'd0, 32'd1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_valid;
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic bus_idle();
        mem_we = 0; mem_rd = 0; mem_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0; out_ready = 0;
        in_valid = 0; in_A = 0; in_B = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_A", A, 32'd0);
        check("rst_B", B, 32'd0);
        check("rst_op", 32'(ALU_operation), 32'd0);
        check("rst_rd", 32'(out_rd), 32'd0);
        @(posedge clk); #1;

        // Single transfer: visible one cycle after acceptance
        out_ready = 1;
        drive(32'd5, 32'd3, 3'd2, 5'd0, 5'd0, 5'd7);
        step();
        in_valid = 0;
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_A", A, 32'd5);
        check("single_B", B, 32'd3);
        check("single_op", 32'(ALU_operation), 32'd2);
        @(posedge clk); #1;
        wait_empty();

        // Backpressure: two accepted, third held off until out_ready rises
        out_ready = 0;
        send(32'h11, 32'h21, 3'd1, 5'd1, 5'd2, 5'd3);
        send(32'h12, 32'h22, 3'd3, 5'd4, 5'd5, 5'd6);
        drive(32'h13, 32'h23, 3'd5, 5'd7, 5'd8, 5'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_main_stable_A", A, 32'h11);
            @(posedge clk); #1;
        end
        out_ready = 1;
        send(32'h13, 32'h23, 3'd5, 5'd7, 5'd8, 5'd9);
        wait_empty();

        // Flush with both entries full and an input presented
        out_ready = 0;
        send(32'h31, 32'h41, 3'd1, 5'd1, 5'd1, 5'd1);
        send(32'h32, 32'h42, 3'd2, 5'd2, 5'd2, 5'd2);
        drive(32'h33, 32'h43, 3'd3, 5'd3, 5'd3, 5'd3);
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1;
        repeat (3) step();
        @(negedge clk);
        check("flush_input_absent", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Forwarding stimulus (expectations depend on the build)
        out_ready = 0;
        send(32'd1, 32'd2, 3'd4, 5'd8, 5'd9, 5'd10);
        mem_we = 1; mem_rd = 8; mem_data = 32'hAA;
        wb_we = 1; wb_rd = 8; wb_data = 32'hBB;
        @(negedge clk);
`ifdef ALU_OPERAND_FORWARD_EN
        check("fwd_mem_A", A, 32'hAA);
`else
        check("nofwd_mem_A", A, 32'd1);
`endif
        check("fwd_B_unmatched", B, 32'd2);
        @(posedge clk); #1;
        mem_we = 0;
        @(negedge clk);
`ifdef ALU_OPERAND_FORWARD_EN
        check("fwd_wb_A", A, 32'hBB);
`else
        check("nofwd_wb_A", A, 32'd1);
`endif
        @(posedge clk); #1;
        bus_idle();
        out_ready = 1;
        wait_empty();
        out_ready = 0;
        send(32'd1, 32'd2, 3'd4, 5'd0, 5'd0, 5'd10);
        mem_we = 1; mem_rd = 0; mem_data = 32'hAA;
        wb_we = 1; wb_rd = 0; wb_data = 32'hBB;
        @(negedge clk);
        check("fwd_rs0_A", A, 32'd1);
        check("fwd_rt0_B", B, 32'd2);
        @(posedge clk); #1;
        bus_idle();
        out_ready = 1;
        wait_empty();

        // Reset mid-stream with main and skid full
        out_ready = 0;
        send(32'h51, 32'h61, 3'd6, 5'd3, 5'd4, 5'd5);
        send(32'h52, 32'h62, 3'd7, 5'd6, 5'd7, 5'd8);
        rst_n = 0;
        step();
        rst_n = 1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_A", A, 32'd0);
        check("mid_rst_B", B, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_op", 32'(ALU_operation), 32'd0);
        @(posedge clk); #1;

        // Random traffic with occasional flush and live result buses
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_A      = $urandom; in_B = $urandom;
            in_op     = 3'($urandom); in_rd = 5'($urandom);
            in_rs     = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            mem_we    = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_we     = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        bus_idle();
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
